// File: rtl/vrased_reset_ctrl.sv
// Violation-to-reset controller: merges NUM_SRC monitor lines into a held CPU reset
// and keeps a por-persistent log (sticky cause, first cause, saturating event count).
module vrased_reset_ctrl #(
  parameter int unsigned         NUM_SRC       = 6,
  parameter logic [15:0]         RESET_HANDLER = 16'h0000,
  parameter int unsigned         HOLD_CYCLES   = 4,
  parameter int unsigned         CNT_W         = 8,
  parameter logic [NUM_SRC-1:0]  ENFORCE_MASK  = {NUM_SRC{1'b1}}
) (
  input  logic               clk,
  input  logic               por,
  input  logic [15:0]        pc,
  input  logic [NUM_SRC-1:0] viol_in,
  input  logic               cause_clr,
  output logic               reset,
  output logic [1:0]         state,
  output logic [NUM_SRC-1:0] cause,
  output logic [NUM_SRC-1:0] first_cause,
  output logic [CNT_W-1:0]   viol_cnt,
  output logic               cnt_sat
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    StRun  = 2'b00,
    StHold = 2'b01,
    StWait = 2'b10,
    StBad  = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [NUM_SRC-1:0] cause_q, cause_d;
  logic [NUM_SRC-1:0] first_cause_q, first_cause_d;
  logic [CNT_W-1:0]   viol_cnt_q, viol_cnt_d;
  logic               prev_any_q, prev_any_d;

  logic enf, any, at_rh, evt, sat;

  assign enf   = |(viol_in & ENFORCE_MASK);
  assign any   = |viol_in;
  assign at_rh = (pc == RESET_HANDLER);
  assign evt   = any & ~prev_any_q;
  assign sat   = &viol_cnt_q;

  always_ff @(posedge clk or posedge por) begin
    if (por) begin
      state_q       <= StRun;
      hold_cnt_q    <= '0;
      cause_q       <= '0;
      first_cause_q <= '0;
      viol_cnt_q    <= '0;
      prev_any_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      cause_q       <= cause_d;
      first_cause_q <= first_cause_d;
      viol_cnt_q    <= viol_cnt_d;
      prev_any_q    <= prev_any_d;
    end
  end

  // Any enforced violation (re)starts the full hold window.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StRun: begin
        if (enf) begin
          state_d    = StHold;
          hold_cnt_d = HoldLoad;
        end
      end
      StHold: begin
        if (enf) begin
          hold_cnt_d = HoldLoad;
        end else if (hold_cnt_q == '0) begin
          state_d = StWait;
        end else begin
          hold_cnt_d = hold_cnt_q - HoldW'(1);
        end
      end
      StWait: begin
        if (enf) begin
          state_d    = StHold;
          hold_cnt_d = HoldLoad;
        end else if (at_rh) begin
          state_d = StRun;
        end
      end
      StBad: state_d = StRun;
    endcase
  end

  // Reset is combinational so a violation in RUN blocks the CPU in the same cycle.
  always_comb begin
    reset = 1'b1;
    unique case (state_q)
      StRun:  reset = enf;
      StHold: reset = 1'b1;
      StWait: reset = ~(at_rh & ~enf);
      StBad:  reset = 1'b1;
    endcase
    if (por) begin
      reset = 1'b0;
    end
  end

  always_comb begin
    cause_d       = (cause_clr ? '0 : cause_q) | viol_in;
    first_cause_d = first_cause_q;
    if (any && ((cause_q == '0) || cause_clr)) begin
      first_cause_d = viol_in;
    end else if (cause_clr) begin
      first_cause_d = '0;
    end
    viol_cnt_d = viol_cnt_q;
    if (evt && !sat) begin
      viol_cnt_d = viol_cnt_q + CNT_W'(1);
    end
    prev_any_d = any;
  end

  assign state       = state_q;
  assign cause       = cause_q;
  assign first_cause = first_cause_q;
  assign viol_cnt    = viol_cnt_q;
  assign cnt_sat     = sat;

endmodule
